// File: rtl/sram_sp_param.sv
// Parametrised single-port SRAM with post-reset init sweep, request/grant handshake,
// 1- or 2-cycle read latency and per-bit write mask. Define SRAM_PARITY_EN for a stored even-parity bit.
module sram_sp_param #(
    parameter int                  DATA_W   = 64,
    parameter int                  DEPTH    = 64,
    parameter int                  READ_LAT = 1,
    parameter logic [DATA_W-1:0]   INIT_VAL = '0,
    localparam int                 AW       = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    output logic              o_gnt,
    input  logic              i_wen,
    input  logic [DATA_W-1:0] i_bit_mask,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_init_done
`ifdef SRAM_PARITY_EN
    ,
    input  logic              i_perr_inj,
    output logic              o_perr
`endif
);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

    state_t            state_reg;
    logic [AW-1:0]     cnt_reg;
    logic              gnt_reg;
    logic              init_done_reg;

    logic              sweep_we;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic              in_range;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              s1_valid_reg;
    logic [DATA_W-1:0] s1_data_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ST_INIT;
            cnt_reg       <= '0;
            gnt_reg       <= 1'b0;
            init_done_reg <= 1'b0;
        end else if (state_reg == ST_INIT) begin
            if (cnt_reg == LAST_ADDR) begin
                state_reg     <= ST_READY;
                cnt_reg       <= '0;
                gnt_reg       <= 1'b1;
                init_done_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign o_gnt       = gnt_reg;
    assign o_init_done = init_done_reg;

    // Grant is only ever high in READY, so it alone qualifies accesses.
    assign sweep_we = (state_reg == ST_INIT) && !i_rst;
    assign acc      = i_req && gnt_reg && !i_rst;
    assign wr_acc   = acc && i_wen;
    assign rd_acc   = acc && !i_wen;
    assign in_range = {1'b0, i_addr} < DEPTH_EXT;

`ifdef SRAM_PARITY_EN
    logic              par_mem [DEPTH];
    logic [DATA_W-1:0] merged;
    logic              s1_par_reg;
    logic              s1_perr;

    assign merged  = (mem[i_addr] & ~i_bit_mask) | (i_wdata & i_bit_mask);
    assign s1_perr = s1_valid_reg & ((^s1_data_reg) ^ s1_par_reg);

    always_ff @(posedge i_clk) begin
        if (sweep_we) begin
            par_mem[cnt_reg] <= ^INIT_VAL;
        end else if (wr_acc && in_range) begin
            par_mem[i_addr] <= (^merged) ^ i_perr_inj;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_par_reg <= 1'b0;
        end else if (rd_acc) begin
            s1_par_reg <= in_range ? par_mem[i_addr] : 1'b0;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (sweep_we) begin
            mem[cnt_reg] <= INIT_VAL;
        end else if (wr_acc && in_range) begin
            for (int b = 0; b < DATA_W; b++) begin
                if (i_bit_mask[b]) begin
                    mem[i_addr][b] <= i_wdata[b];
                end
            end
        end
    end

    // First read stage: registered array output; out-of-range reads return zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
        end else begin
            s1_valid_reg <= rd_acc;
            if (rd_acc) begin
                s1_data_reg <= in_range ? mem[i_addr] : '0;
            end
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            assign o_rvalid = s1_valid_reg;
            assign o_rdata  = s1_data_reg;
`ifdef SRAM_PARITY_EN
            assign o_perr   = s1_perr;
`endif
        end else if (READ_LAT == 2) begin : g_lat2
            logic              rvalid_reg;
            logic [DATA_W-1:0] rdata_reg;
`ifdef SRAM_PARITY_EN
            logic              perr_reg;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    perr_reg <= 1'b0;
                end else begin
                    perr_reg <= s1_perr;
                end
            end
            assign o_perr = perr_reg;
`endif
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        rdata_reg <= s1_data_reg;
                    end
                end
            end
            assign o_rvalid = rvalid_reg;
            assign o_rdata  = rdata_reg;
        end else begin : g_bad_lat
            $error("sram_sp_param: READ_LAT must be 1 or 2");
            assign o_rvalid = 1'b0;
            assign o_rdata  = '0;
`ifdef SRAM_PARITY_EN
            assign o_perr   = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sram_sp_param.sv
// Scoreboard bench for sram_sp_param: instance A (DEPTH 64, READ_LAT 2) and instance B
// (DEPTH 48, READ_LAT 1, nonzero INIT_VAL) share one stimulus stream; monitors check returns.
module tb_sram_sp_param;

    localparam logic [63:0] INIT_A = 64'h0;
    localparam logic [63:0] INIT_B = 64'hDEAD_BEEF_0123_4567;

    typedef struct {
        logic [63:0] data;
        int          stamp;
        logic        perr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wen;
    logic [63:0] mask;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic        perr_inj;

    logic        gnt_a, rvalid_a, done_a, perr_a;
    logic [63:0] rdata_a;
    logic        gnt_b, rvalid_b, done_b, perr_b;
    logic [63:0] rdata_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_sp_param #(.DATA_W(64), .DEPTH(64), .READ_LAT(2), .INIT_VAL(INIT_A)) u_a (
        .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt_a), .i_wen(wen),
        .i_bit_mask(mask), .i_addr(addr), .i_wdata(wdata), .o_rvalid(rvalid_a),
        .o_rdata(rdata_a), .o_init_done(done_a)
`ifdef SRAM_PARITY_EN
        , .i_perr_inj(perr_inj), .o_perr(perr_a)
`endif
    );

    sram_sp_param #(.DATA_W(64), .DEPTH(48), .READ_LAT(1), .INIT_VAL(INIT_B)) u_b (
        .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt_b), .i_wen(wen),
        .i_bit_mask(mask), .i_addr(addr), .i_wdata(wdata), .o_rvalid(rvalid_b),
        .o_rdata(rdata_b), .o_init_done(done_b)
`ifdef SRAM_PARITY_EN
        , .i_perr_inj(perr_inj), .o_perr(perr_b)
`endif
    );

`ifndef SRAM_PARITY_EN
    assign perr_a = 1'b0;
    assign perr_b = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Drive helpers are called #1 after a rising edge; cyc then names that edge.
    task automatic do_read(input logic [5:0] a, input logic [63:0] ea, input logic [63:0] eb,
                           input logic pa, input logic pb);
        req = 1'b1; wen = 1'b0; addr = a;
        qa.push_back('{ea, cyc + 2, pa});
        qb.push_back('{eb, cyc + 1, pb});
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [63:0] d, input logic [63:0] m,
                            input logic inj);
        req = 1'b1; wen = 1'b1; addr = a; wdata = d; mask = m; perr_inj = inj;
        @(posedge clk); #1;
        req = 1'b0; wen = 1'b0; perr_inj = 1'b0;
        $display("write addr=%0d data=%h mask=%h inj=%0b", a, d, m, inj);
    endtask

    always @(negedge clk) begin
        if (rvalid_a) begin
            if (qa.size() == 0) begin
                check("a_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_rdata", rdata_a, e.data);
                check("a_latency", 64'(cyc), 64'(e.stamp));
`ifdef SRAM_PARITY_EN
                check("a_perr", {63'd0, perr_a}, {63'd0, e.perr});
`endif
            end
        end
        if (rvalid_b) begin
            if (qb.size() == 0) begin
                check("b_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_rdata", rdata_b, e.data);
                check("b_latency", 64'(cyc), 64'(e.stamp));
`ifdef SRAM_PARITY_EN
                check("b_perr", {63'd0, perr_b}, {63'd0, e.perr});
`endif
            end
        end
`ifdef SRAM_PARITY_EN
        if ((!rvalid_a && perr_a) || (!rvalid_b && perr_b)) begin
            check("perr_without_rvalid", 64'd1, 64'd0);
        end
`endif
    end

    initial begin
        int t_a;
        int t_b;
        rst = 1'b1; req = 1'b0; wen = 1'b0; mask = '0; addr = '0; wdata = '0; perr_inj = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_gnt", {63'd0, gnt_a}, 64'd0);
        check("a_reset_done", {63'd0, done_a}, 64'd0);
        check("a_reset_rvalid", {63'd0, rvalid_a}, 64'd0);
        check("a_reset_rdata", rdata_a, 64'd0);
        check("b_reset_gnt", {63'd0, gnt_b}, 64'd0);
        check("b_reset_done", {63'd0, done_b}, 64'd0);
        check("b_reset_rvalid", {63'd0, rvalid_b}, 64'd0);
        check("b_reset_perr", {63'd0, perr_b}, 64'd0);

        // Release, then pulse reset 30 cycles into the sweep; reads during INIT must be dropped.
        rst = 1'b0; req = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        t_a = 0;
        t_b = 0;
        for (int n = 1; n <= 200 && t_a == 0; n++) begin
            @(posedge clk); #1;
            if (n == 40) req = 1'b0;
            if (gnt_b && t_b == 0) begin
                t_b = n;
                check("b_done_with_gnt", {63'd0, done_b}, 64'd1);
            end
            if (gnt_a && t_a == 0) begin
                t_a = n;
                check("a_done_with_gnt", {63'd0, done_a}, 64'd1);
            end
        end
        check("a_sweep_cycles", 64'(t_a), 64'd64);
        check("b_sweep_cycles", 64'(t_b), 64'd48);

        // Back-to-back reads of every A word; B returns INIT_B in range and 0 beyond 47.
        for (int i = 0; i < 64; i++) begin
            do_read(6'(i), INIT_A, (i < 48) ? INIT_B : 64'd0, 1'b0, 1'b0);
        end

        do_write(6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000, 1'b0);
        do_read(6'd5, 64'h0000_0000_FFFF_0000, 64'hDEAD_BEEF_FFFF_4567, 1'b0, 1'b0);

        do_write(6'd47, 64'hA5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        do_write(6'd50, 64'h5A, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        do_read(6'd47, 64'hA5, 64'hA5, 1'b0, 1'b0);
        do_read(6'd50, 64'h5A, 64'h0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        do_read(6'd1, INIT_A, INIT_B, 1'b0, 1'b0);
        do_read(6'd2, INIT_A, INIT_B, 1'b0, 1'b0);
        do_read(6'd3, INIT_A, INIT_B, 1'b0, 1'b0);

        do_write(6'd7, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        do_read(6'd7, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

        do_write(6'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
        do_read(6'd8, INIT_A, INIT_B, 1'b0, 1'b0);

        do_write(6'd9, 64'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        do_write(6'd10, 64'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        do_read(6'd9, 64'h0F, 64'h0F, 1'b1, 1'b1);
        do_read(6'd10, 64'h0F, 64'h0F, 1'b0, 1'b0);

        repeat (6) @(posedge clk);
        #1;
        check("a_queue_drained", 64'(qa.size()), 64'd0);
        check("b_queue_drained", 64'(qb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_sp_param.md
Name: sram_sp_param

Overview:
- Parametrised single-port SRAM block for on-chip buffers.
- Generalises the fixed 64-entry x 64-bit wrapper to arbitrary width and depth.
- Adds a post-reset initialisation sweep, a request/grant handshake, a selectable read latency and per-bit masked writes.
- Sits between shield-side control logic and storage; behavioural array inside, swappable for a foundry macro without port changes.

Parameters:
- DATA_W, 64, word width in bits (1..256).
- DEPTH, 64, number of words (2..4096, need not be a power of 2).
- READ_LAT, 1, read latency in cycles: 1 = array output, 2 = extra output register. Any other value fails elaboration.
- INIT_VAL, 0, DATA_W-bit value written to every word during the init sweep.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_req  in  1  access request (chip enable)
- o_gnt  out  1  block ready to accept an access this cycle
- i_wen  in  1  1 = write, 0 = read (sampled with i_req)
- i_bit_mask  in  DATA_W  write mask, 1 = bit is written
- i_addr  in  AW  word address
- i_wdata  in  DATA_W  write data
- o_rvalid  out  1  read data valid pulse
- o_rdata  out  DATA_W  read data
- o_init_done  out  1  init sweep finished
- i_perr_inj  in  1  (SRAM_PARITY_EN only) corrupt stored parity of this write
- o_perr  out  1  (SRAM_PARITY_EN only) parity error on the returned read

Behaviour:
- One clock (i_clk). Synchronous active-high reset (i_rst). All state changes on the rising edge.
- Reset values: o_gnt=0, o_rvalid=0, o_rdata=0, o_init_done=0, o_perr=0, internal state=INIT, sweep counter=0. Array contents are not reset directly; the sweep overwrites them.
- FSM states: INIT and READY.
  - INIT: writes INIT_VAL (and its parity, when enabled) to address cnt each cycle, cnt = 0..DEPTH-1. After the write to address DEPTH-1, the next state is READY. The sweep takes exactly DEPTH cycles after reset deasserts.
  - READY: o_gnt=1 and o_init_done=1 continuously. Both are registered and go high together on the first READY cycle.
  - i_rst asserted mid-sweep restarts the sweep at address 0. i_rst in READY returns to INIT and a full re-sweep runs.
- Accept rule: an access is accepted when i_req && o_gnt. Requests while o_gnt=0 are ignored and dropped (no queuing).
- Write: mem[a] <= (mem[a] & ~i_bit_mask) | (i_wdata & i_bit_mask). A write produces no o_rvalid. A mask of all zeros leaves the word unchanged.
- Read, READ_LAT=1: o_rvalid=1 and o_rdata=mem[a] in cycle N+1 after acceptance in cycle N.
- Read, READ_LAT=2: o_rvalid and o_rdata appear in cycle N+2.
- Back-to-back reads: one read per cycle with full throughput. Each o_rvalid is a single-cycle pulse per read.
- o_rdata holds its last read value until the next read returns. In-flight read results are discarded on i_rst.
- Read of the address written in the previous cycle returns the merged new data (write-then-read ordering).
- Out-of-range address (i_addr >= DEPTH): the write is dropped. The read returns 0 with o_rvalid still pulsed at normal latency.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed over the merged word on every write and init write.
  - i_perr_inj=1 on an accepted write stores the inverted parity bit.
  - On read return, o_perr = parity mismatch, aligned with o_rvalid; o_perr=0 whenever o_rvalid=0.
  - An out-of-range read returns o_perr=0.
- Undefined: ports i_perr_inj and o_perr are absent, with no extra storage bit.

Test Plan:
- Init sweep: DEPTH=64, release i_rst at cycle 0 -> o_gnt/o_init_done stay 0 for 64 cycles and go 1 at cycle 64. Reading all 64 words then returns INIT_VAL.
- Masked write: write addr 5 with data 0xFFFF_FFFF_FFFF_FFFF, mask 0x0000_0000_FFFF_0000, over INIT_VAL=0 -> read addr 5 returns 0x0000_0000_FFFF_0000.
- Latency and throughput: READ_LAT=2, reads of addrs 1,2,3 in consecutive cycles N..N+2 -> o_rvalid high in cycles N+2..N+4 with the matching data. Repeat with READ_LAT=1: returns in N+1..N+3.
- Reset mid-sweep: assert i_rst at sweep cycle 30 for 1 cycle -> sweep restarts and o_init_done rises exactly 64 cycles after the release. Requests issued during INIT are dropped and produce no o_rvalid.
- Boundaries: DEPTH=48, write 0xA5 to addr 47 then 0x5A to addr 50 -> read 47 = 0xA5; read 50 = 0 with o_rvalid pulsed. Write addr 7 then read addr 7 in the next cycle -> new data.
- Parity (SRAM_PARITY_EN): write addr 9 with i_perr_inj=1, write addr 10 normally -> read 9 gives o_perr=1 with o_rvalid; read 10 gives o_perr=0.
